imem_loader: RTL and testbench

- Program loader that writes the instruction memory from a byte stream (debug/UART side) before the core runs.
- Parses a framed image (length header, payload, checksum) and assembles little-endian 32-bit words.
- Issues one word-write per assembled word to the instruction memory write port.
- Holds the core in reset while loading.

---
 rtl/imem_loader.sv | 109 ++++++++++
 tb/tb_imem_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a framed image (length, payload, XOR checksum)
// and writes little-endian 32-bit words into the instruction memory while the core is held.
module imem_loader #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2048
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [7:0]      byte_i,
  input  logic            byte_valid_i,
  output logic            byte_ready_o,
  output logic            we_o,
  output logic [XLEN-1:0] waddr_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            busy_o,
  output logic            core_hold_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int AW = $clog2(DEPTH * 4);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CSUM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]      state;
  logic [1:0]      byte_cnt;
  logic [AW-3:0]   word_cnt;
  logic [XLEN-1:0] len_q;
  logic [XLEN-1:0] asm_q;
  logic [7:0]      csum_q;
  logic [XLEN-1:0] asm_next;
  logic            accept;

  // Bytes enter at the top and shift down, so the first byte ends up in [7:0].
  assign asm_next = {byte_i, asm_q[XLEN-1:8]};
  assign accept   = byte_valid_i && byte_ready_o;

  assign byte_ready_o = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign busy_o       = byte_ready_o;
  assign core_hold_o  = busy_o || (state == S_ERROR);
  assign done_o       = (state == S_DONE);
  assign err_o        = (state == S_ERROR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      word_cnt <= '0;
      len_q    <= '0;
      asm_q    <= '0;
      csum_q   <= '0;
      we_o     <= 1'b0;
      waddr_o  <= '0;
      wdata_o  <= '0;
    end else begin
      we_o <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state    <= S_LEN;
            byte_cnt <= '0;
            word_cnt <= '0;
            len_q    <= '0;
            asm_q    <= '0;
            csum_q   <= '0;
          end
        end
        S_LEN: begin
          if (accept) begin
            asm_q    <= asm_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              len_q <= asm_next;
              if (asm_next > XLEN'(DEPTH)) state <= S_ERROR;
              else if (asm_next == '0)     state <= S_CSUM;
              else                         state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            asm_q    <= asm_next;
            csum_q   <= csum_q ^ byte_i;
            byte_cnt <= byte_cnt + 2'd1;
            // Write stage: the completed word is presented one cycle after its last byte.
            if (byte_cnt == 2'd3) begin
              we_o     <= 1'b1;
              wdata_o  <= asm_next;
              waddr_o  <= XLEN'({word_cnt, 2'b00});
              word_cnt <= word_cnt + (AW-2)'(1);
              if (XLEN'(word_cnt) == len_q - XLEN'(1)) state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (accept) state <= (byte_i == csum_q) ? S_DONE : S_ERROR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed image loads, stalls, bad checksum, length limits, reset and restart.
module tb_imem_loader;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2048;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [7:0]      bdat = 8'h00;
  logic            bvld = 1'b0;
  logic            brdy;
  logic            we;
  logic [XLEN-1:0] waddr;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            hold;
  logic            done;
  logic            err;

  int checks = 0;
  int errors = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  run_xor;

  imem_loader #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .byte_i(bdat),
    .byte_valid_i(bvld), .byte_ready_o(brdy), .we_o(we), .waddr_o(waddr),
    .wdata_o(wdata), .busy_o(busy), .core_hold_o(hold), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  // Write log, sampled on the inactive edge.
  always @(negedge clk) begin
    if (we) begin
      wa.push_back(waddr);
      wd.push_back(wdata);
    end
  end

  task automatic send_byte(input logic [7:0] v, input int max_stall);
    if (max_stall > 0) begin
      bvld = 1'b0;
      repeat ($urandom_range(1, max_stall)) @(posedge clk);
      #1;
    end
    bvld = 1'b1;
    bdat = v;
    @(posedge clk);
    #1;
    bvld = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] n);
    run_xor = 8'h00;
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 0);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_stall);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], max_stall);
      run_xor = run_xor ^ w[8*i +: 8];
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({brdy, we, busy, hold, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000000", {brdy, we, busy, hold, done, err});
    end
    checks++;
    if ({waddr, wdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus got=%h exp=0", {waddr, wdata});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    wa.delete(); wd.delete();
    pulse_start();
    checks++;
    if ({busy, brdy, hold, done, err} !== 5'b11100) begin
      errors++;
      $display("FAIL nominal_start_flags got=%b exp=11100", {busy, brdy, hold, done, err});
    end
    send_header(32'd2);
    send_word(32'h00100513, 0);
    checks++;
    if ({we, waddr, wdata} !== {1'b1, 32'h0, 32'h00100513}) begin
      errors++;
      $display("FAIL nominal_write_latency got=%b/%h/%h exp=1/00000000/00100513", we, waddr, wdata);
    end
    send_word(32'h00200593, 0);
    send_byte(run_xor, 0);
    checks++;
    if (run_xor !== 8'hB0 || wa.size() != 2 || wa[0] !== 32'h0 || wd[0] !== 32'h00100513 ||
        wa[1] !== 32'h4 || wd[1] !== 32'h00200593) begin
      errors++;
      $display("FAIL nominal_writes got=%0d writes exp=2 (0:00100513, 4:00200593)", wa.size());
    end
    checks++;
    if ({busy, brdy, hold, done, err} !== 5'b00010) begin
      errors++;
      $display("FAIL nominal_end_flags got=%b exp=00010", {busy, brdy, hold, done, err});
    end
  endtask

  task automatic test_stall();
    wa.delete(); wd.delete();
    pulse_start();
    send_header(32'd2);
    send_word(32'h00100513, 3);
    send_word(32'h00200593, 3);
    send_byte(run_xor, 3);
    checks++;
    if (wa.size() != 2 || wa[0] !== 32'h0 || wd[0] !== 32'h00100513 ||
        wa[1] !== 32'h4 || wd[1] !== 32'h00200593) begin
      errors++;
      $display("FAIL stall_writes got=%0d writes exp=2 (0:00100513, 4:00200593)", wa.size());
    end
    checks++;
    if ({hold, done, err} !== 3'b010) begin
      errors++;
      $display("FAIL stall_end_flags got=%b exp=010", {hold, done, err});
    end
  endtask

  task automatic test_bad_csum();
    wa.delete(); wd.delete();
    pulse_start();
    send_header(32'd1);
    send_word(32'h00000013, 0);
    send_byte(8'h00, 0);
    checks++;
    if (wa.size() != 1 || wa[0] !== 32'h0 || wd[0] !== 32'h00000013) begin
      errors++;
      $display("FAIL badcsum_writes got=%0d writes exp=1 (0:00000013)", wa.size());
    end
    checks++;
    if ({busy, hold, done, err} !== 4'b0101) begin
      errors++;
      $display("FAIL badcsum_flags got=%b exp=0101", {busy, hold, done, err});
    end
  endtask

  task automatic test_len_zero();
    wa.delete(); wd.delete();
    pulse_start();
    checks++;
    if ({done, err} !== 2'b00) begin
      errors++;
      $display("FAIL restart_clears_flags got=%b exp=00", {done, err});
    end
    send_header(32'd0);
    send_byte(8'h00, 0);
    checks++;
    if (wa.size() != 0 || {done, err, hold} !== 3'b100) begin
      errors++;
      $display("FAIL len_zero got=%0d writes flags=%b exp=0 writes flags=100", wa.size(), {done, err, hold});
    end
  endtask

  task automatic test_len_overflow();
    wa.delete(); wd.delete();
    pulse_start();
    send_header(32'd2049);
    checks++;
    if ({brdy, busy, hold, err, done} !== 5'b00110) begin
      errors++;
      $display("FAIL len_overflow_flags got=%b exp=00110", {brdy, busy, hold, err, done});
    end
    bvld = 1'b1;
    bdat = 8'hAA;
    repeat (4) @(posedge clk);
    #1;
    bvld = 1'b0;
    checks++;
    if (wa.size() != 0 || brdy !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL len_overflow_after got=%0d writes rdy=%b err=%b exp=0 writes rdy=0 err=1", wa.size(), brdy, err);
    end
  endtask

  task automatic test_len_max();
    wa.delete(); wd.delete();
    pulse_start();
    send_header(32'd2048);
    for (int i = 0; i < 2048; i++) send_word(32'hFFFFFFFF, 0);
    send_byte(run_xor, 0);
    checks++;
    if (wa.size() != 2048) begin
      errors++;
      $display("FAIL len_max_count got=%0d exp=2048", wa.size());
    end else begin
      checks++;
      if (wa[2047] !== 32'h1FFC || wd[2047] !== 32'hFFFFFFFF || wa[1] !== 32'h4) begin
        errors++;
        $display("FAIL len_max_last got=%h/%h exp=00001ffc/ffffffff", wa[2047], wd[2047]);
      end
    end
    checks++;
    if ({done, err} !== 2'b10) begin
      errors++;
      $display("FAIL len_max_done got=%b exp=10", {done, err});
    end
  endtask

  task automatic test_reset_mid_load();
    wa.delete(); wd.delete();
    pulse_start();
    send_header(32'd2);
    send_word(32'h00100513, 0);
    send_byte(8'h93, 0);
    send_byte(8'h05, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({brdy, we, busy, hold, done, err} !== 6'b0 || {waddr, wdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid got=%b/%h/%h exp=000000/0/0", {brdy, we, busy, hold, done, err}, waddr, wdata);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wa.delete(); wd.delete();
    pulse_start();
    send_header(32'd2);
    send_word(32'h00100513, 0);
    send_word(32'h00200593, 0);
    send_byte(run_xor, 0);
    checks++;
    if (wa.size() != 2 || wa[0] !== 32'h0 || wd[0] !== 32'h00100513 ||
        wa[1] !== 32'h4 || wd[1] !== 32'h00200593 || done !== 1'b1) begin
      errors++;
      $display("FAIL reset_reload got=%0d writes done=%b exp=2 writes done=1", wa.size(), done);
    end
  endtask

  task automatic test_start_busy();
    wa.delete(); wd.delete();
    pulse_start();
    send_header(32'd2);
    send_word(32'h00100513, 0);
    send_byte(8'h93, 0);
    pulse_start();
    checks++;
    if ({busy, done, err} !== 3'b100) begin
      errors++;
      $display("FAIL start_busy_flags got=%b exp=100", {busy, done, err});
    end
    send_byte(8'h05, 0);
    send_byte(8'h20, 0);
    send_byte(8'h00, 0);
    send_byte(8'hB0, 0);
    checks++;
    if (wa.size() != 2 || wa[1] !== 32'h4 || wd[1] !== 32'h00200593 || {done, err} !== 2'b10) begin
      errors++;
      $display("FAIL start_busy_result got=%0d writes flags=%b exp=2 writes flags=10", wa.size(), {done, err});
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_bad_csum();
    test_len_zero();
    test_len_overflow();
    test_len_max();
    test_reset_mid_load();
    test_start_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
